// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: drain states, record layout and
// the mapping from a stored record to its four frame words.
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        W1,
        W2,
        W3
    } drain_state_t;

    localparam logic [1:0] WORD_PC    = 2'd0;
    localparam logic [1:0] WORD_INSTR = 2'd1;
    localparam logic [1:0] WORD_WB    = 2'd2;
    localparam logic [1:0] WORD_DATA  = 2'd3;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int WADDR_W = 5;
    localparam int WDATA_W = 32;
    localparam int SEQ_W   = 16;
    localparam int REC_W   = PC_W + INSTR_W + 1 + WADDR_W + WDATA_W + SEQ_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               rf_we;
        logic [WADDR_W-1:0] waddr;
        logic [WDATA_W-1:0] wdata;
        logic [SEQ_W-1:0]   seq;
    } trace_rec_t;

    // Write-back data is masked when no register was written, so the sink
    // never sees stale wdata from the core.
    function automatic logic [31:0] frame_word(input trace_rec_t rec, input logic [1:0] idx);
        logic [31:0] word;
        case (idx)
            WORD_PC:    word = rec.pc;
            WORD_INSTR: word = rec.instr;
            WORD_WB:    word = {rec.rf_we, 10'b0, rec.waddr, rec.seq};
            default:    word = rec.rf_we ? rec.wdata : 32'h0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-side capture signals plus the outgoing frame-word stream.
interface commit_trace_buffer_if;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [31:0] in_rf_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;

    modport master (
        output in_valid, in_pc, in_instr, in_rf_we, in_rf_waddr, in_rf_wdata, out_ready,
        input  out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_rf_we, in_rf_waddr, in_rf_wdata, out_ready,
        output out_valid, out_word, out_last
    );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a combinational head output; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module trace_fifo #(
    parameter int WIDTH = 118,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures one record per retired instruction and drains each as a 4-word
// frame; never stalls the core, drops and counts records when full.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  trace,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    drain_state_t state_reg;
    logic         out_valid_reg;
    logic         out_last_reg;
    logic [15:0]  seq_reg;
    logic         overflow_reg;
    logic [15:0]  drop_cnt_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [REC_W-1:0] fifo_dout;
    trace_rec_t       push_rec;
    trace_rec_t       head_rec;
    logic             push;
    logic             pop;
    logic             drop;
    logic             more_after_pop;
    logic [31:0]      frame_words [4];
    logic [31:0]      out_word_next;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = (state_reg == W3) && trace.out_ready;
    assign push = trace.in_valid && (!fifo_full || pop);
    assign drop = trace.in_valid && fifo_full && !pop;
    assign more_after_pop = push || (fifo_count > {{AW{1'b0}}, 1'b1});

    assign push_rec = '{pc:    trace.in_pc,
                        instr: trace.in_instr,
                        rf_we: trace.in_rf_we,
                        waddr: trace.in_rf_waddr,
                        wdata: trace.in_rf_wdata,
                        seq:   seq_reg};

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_rec = trace_rec_t'(fifo_dout);

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        assign frame_words[gi] = frame_word(head_rec, 2'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (trace.in_valid) seq_reg <= seq_reg + 1'b1;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (!fifo_empty) begin
                    state_reg     <= W0;
                    out_valid_reg <= 1'b1;
                end
                W0: if (trace.out_ready) state_reg <= W1;
                W1: if (trace.out_ready) state_reg <= W2;
                W2: if (trace.out_ready) begin
                    state_reg    <= W3;
                    out_last_reg <= 1'b1;
                end
                W3: if (trace.out_ready) begin
                    out_last_reg <= 1'b0;
                    if (more_after_pop) begin
                        state_reg <= W0;
                    end else begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_word_next = 32'h0;
        case (state_reg)
            W0:      out_word_next = frame_words[WORD_PC];
            W1:      out_word_next = frame_words[WORD_INSTR];
            W2:      out_word_next = frame_words[WORD_WB];
            W3:      out_word_next = frame_words[WORD_DATA];
            default: out_word_next = 32'h0;
        endcase
    end

    assign trace.out_valid = out_valid_reg;
    assign trace.out_last  = out_last_reg;
    assign trace.out_word  = out_word_next;
    assign overflow        = overflow_reg;
    assign drop_cnt        = drop_cnt_reg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: framing, backpressure, overflow,
// full push/pop collision and mid-frame reset.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        overflow;
    logic [15:0] drop_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    commit_trace_buffer_if bus ();

    commit_trace_buffer #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .trace    (bus),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                          input logic [4:0] waddr, input logic [31:0] wdata);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_instr    = instr;
        bus.in_rf_we    = we;
        bus.in_rf_waddr = waddr;
        bus.in_rf_wdata = wdata;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.in_rf_we = 1'b0;
        bus.in_rf_waddr = '0; bus.in_rf_wdata = '0; bus.out_ready = 1'b0;
        rst = 1'b0;
        step(); step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_word !== 32'h0) begin n_bad++; $display("FAIL reset_out_word: got %h want 0", bus.out_word); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
        rst = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got %b want 0", bus.out_valid); end
        $display("reset: out_valid=%b drop_cnt=%h", bus.out_valid, drop_cnt);
    endtask

    task automatic test_single_frame();
        logic [31:0] exp [4];
        exp[0] = 32'h0000_3000; exp[1] = 32'h2008_0005; exp[2] = 32'h8008_0000; exp[3] = 32'h0000_0005;
        bus.out_ready = 1'b1;
        retire(32'h0000_3000, 32'h2008_0005, 1'b1, 5'd8, 32'h5);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency: out_valid got %b want 0", bus.out_valid); end
        step();
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp[w] || bus.out_last !== (w == 3)) begin
                n_bad++; $display("FAIL single_w%0d: got v=%b %h last=%b want v=1 %h last=%b", w, bus.out_valid, bus.out_word, bus.out_last, exp[w], (w == 3));
            end
            $display("single frame word %0d: %h last=%b", w, bus.out_word, bus.out_last);
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_end: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_no_writeback();
        logic [31:0] exp [4];
        exp[0] = 32'h0000_3004; exp[1] = 32'h0000_0013; exp[2] = 32'h0009_0001; exp[3] = 32'h0000_0000;
        retire(32'h0000_3004, 32'h0000_0013, 1'b0, 5'd9, 32'h1234);
        step();
        bus.in_valid = 1'b0;
        step();
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (bus.out_word !== exp[w] || bus.out_last !== (w == 3)) begin
                n_bad++; $display("FAIL nowb_w%0d: got %h last=%b want %h last=%b", w, bus.out_word, bus.out_last, exp[w], (w == 3));
            end
            $display("no-wb frame word %0d: %h", w, bus.out_word);
            step();
        end
    endtask

    task automatic test_backpressure();
        retire(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h7);
        step();
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_word !== 32'h0000_0100) begin n_bad++; $display("FAIL bp_w0: got %h want 00000100", bus.out_word); end
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hDEAD_BEEF || bus.out_last !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b %h last=%b want v=1 deadbeef last=0", c, bus.out_valid, bus.out_word, bus.out_last);
            end
            $display("backpressure cycle %0d: %h", c, bus.out_word);
            if (c < 5) step();
        end
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_word !== 32'h8003_0002) begin n_bad++; $display("FAIL bp_w2: got %h want 80030002", bus.out_word); end
        step();
        n_cmp++; if (bus.out_word !== 32'h7 || bus.out_last !== 1'b1) begin n_bad++; $display("FAIL bp_w3: got %h last=%b want 00000007 last=1", bus.out_word, bus.out_last); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_end: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire(32'h1000 + 32'(4 * i), 32'h0100_0000 | 32'(i), 1'b1, 5'(i), 32'(3 * i + 1));
            step();
            if (i == 15) begin
                n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
                    n_bad++; $display("FAIL ovf_at_16: got ovf=%b drop=%0d want ovf=0 drop=0", overflow, drop_cnt);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 4", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h0000_1000) begin
            n_bad++; $display("FAIL ovf_head: got v=%b %h want v=1 00001000", bus.out_valid, bus.out_word);
        end
        $display("overflow: drop_cnt=%0d overflow=%b", drop_cnt, overflow);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [4];
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_word !== 32'h0100_0000) begin n_bad++; $display("FAIL fpp_w1: got %h want 01000000", bus.out_word); end
        step();
        n_cmp++; if (bus.out_word !== 32'h8000_0000) begin n_bad++; $display("FAIL fpp_w2_seq0: got %h want 80000000", bus.out_word); end
        step();
        n_cmp++; if (bus.out_word !== 32'h1 || bus.out_last !== 1'b1) begin n_bad++; $display("FAIL fpp_w3: got %h last=%b want 00000001 last=1", bus.out_word, bus.out_last); end
        retire(32'hABCD_0000, 32'h0000_0013, 1'b0, 5'd0, 32'h55);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL fpp_no_drop: drop_cnt got %0d want 4", drop_cnt); end
        for (int f = 1; f <= 16; f++) begin
            if (f <= 15) begin
                exp[0] = 32'h1000 + 32'(4 * f);
                exp[1] = 32'h0100_0000 | 32'(f);
                exp[2] = 32'h8000_0000 | (32'(f) << 16) | 32'(f);
                exp[3] = 32'(3 * f + 1);
            end else begin
                exp[0] = 32'hABCD_0000; exp[1] = 32'h0000_0013; exp[2] = 32'h0000_0014; exp[3] = 32'h0;
            end
            for (int w = 0; w < 4; w++) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp[w]) begin
                    n_bad++; $display("FAIL drain_f%0d_w%0d: got v=%b %h want v=1 %h", f, w, bus.out_valid, bus.out_word, exp[w]);
                end
                step();
            end
            $display("drained frame %0d: w2=%h", f, exp[2]);
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] exp [4];
        exp[0] = 32'h0000_3000; exp[1] = 32'h0000_0033; exp[2] = 32'h8001_0000; exp[3] = 32'h9;
        bus.out_ready = 1'b1;
        retire(32'h0000_2000, 32'h1111_2222, 1'b1, 5'd31, 32'hCAFE);
        step();
        bus.in_valid = 1'b0;
        step(); step(); step();
        n_cmp++; if (bus.out_word !== 32'h801F_0015) begin n_bad++; $display("FAIL mid_w2: got %h want 801f0015", bus.out_word); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_word !== 32'h0) begin
            n_bad++; $display("FAIL mid_rst_out: got v=%b %h want v=0 00000000", bus.out_valid, bus.out_word);
        end
        n_cmp++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_drop: got drop=%0d ovf=%b want 0 0", drop_cnt, overflow);
        end
        #2;
        rst = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_replay: out_valid got %b want 0", bus.out_valid); end
        step();
        retire(32'h0000_3000, 32'h0000_0033, 1'b1, 5'd1, 32'h9);
        step();
        bus.in_valid = 1'b0;
        step();
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (bus.out_word !== exp[w]) begin
                n_bad++; $display("FAIL post_rst_w%0d: got %h want %h", w, bus.out_word, exp[w]);
            end
            $display("post-reset frame word %0d: %h", w, bus.out_word);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_no_writeback();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Captures one record per retired instruction from the single-cycle CPU core (PC, instruction word, register write-back) into an on-chip FIFO. It drains the records as 4-word frames over a valid/ready stream toward a debug sink such as a UART or trace port. It sits directly downstream of the CPU core and observes its commit signals without ever stalling it. Records that arrive while the FIFO is full are dropped and counted, and a sequence number lets the sink detect gaps.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- AW, $clog2(DEPTH): FIFO pointer width.
- clk  in  1  rising-edge clock, shared with the CPU core.
- rst  in  1  asynchronous, active-low reset; asserted at 0.
- in_valid  in  1  one instruction retired this cycle.
- in_pc  in  32  byte address of the retired instruction.
- in_instr  in  32  retired instruction word.
- in_rf_we  in  1  register file written this cycle.
- in_rf_waddr  in  5  destination register.
- in_rf_wdata  in  32  value written.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  sink accepts out_word.
- out_word  out  32  current frame word.
- out_last  out  1  high on word 3 of a frame.
- overflow  out  1  sticky flag; set on the first dropped record.
- drop_cnt  out  16  dropped records; saturates at 16'hFFFF.

## Operation
- seq: 16-bit retire counter.
  - Increments (wrapping) on every in_valid, whether the record is stored or dropped.
  - The stored record carries the pre-increment value.
- Push: in_valid=1 and the FIFO is not full → store {pc, instr, rf_we, waddr, wdata, seq}.
- Drop: in_valid=1 and the FIFO is full, with no pop completing this cycle → discard the record; drop_cnt++ (saturating); overflow←1.
- Frame words:
  - w0 = pc.
  - w1 = instr.
  - w2 = {rf_we, 10'b0, waddr, seq}.
  - w3 = rf_we ? wdata : 32'h0.
- Drain FSM states: IDLE, W0, W1, W2, W3.
  - IDLE → W0 when the FIFO is not empty.
  - Wn → Wn+1 on out_valid & out_ready.
  - W3 handshake pops the head entry, then → W0 if the FIFO is still non-empty, else → IDLE.
- out_valid=1 in W0–W3 and 0 in IDLE. out_word is selected from the head entry by state.
- Words of a frame are never skipped or reordered, and a frame is never interrupted.
- overflow and drop_cnt clear only on reset.

## Timing
- Reset (rst=0) values:
  - out_valid=0, out_word=0, out_last=0.
  - overflow=0, drop_cnt=0.
  - seq=0, FIFO empty, FSM=IDLE.
- Reset mid-frame aborts the frame immediately; that partial frame is not replayed.
- Latency: a record pushed at edge N enters W0 at edge N+1, so out_valid is high after edge N+1.
- Throughput: one frame word per cycle when out_ready is held at 1, i.e. 4 cycles per record.
- Handshake rules:
  - out_word and out_last are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- Full with simultaneous push and W3 pop: the push is accepted and the count is unchanged (no drop).
- Empty: no pop is possible because the FSM is in IDLE, so a push into an empty FIFO never collides with a pop.
- Pointers are AW bits plus a wrap bit. full = pointers equal except for the wrap bit.
- drop_cnt at 16'hFFFF stays at 16'hFFFF.
- seq wraps 16'hFFFF → 16'h0000.

## Structure
- trace_pkg holds:
  - the drain state enum (IDLE, W0..W3);
  - frame-word index constants;
  - the record field widths (REC_W = 118).
- One natural sub-module: trace_fifo.
  - Parameterised width/depth synchronous FIFO.
  - Ports: push, pop, din, dout (head), full, empty.
  - Same clk and active-low asynchronous rst.
- The top level holds the seq counter, the drop logic and the drain FSM.

## Test plan
- Reset, then 1 retire (pc=0x0000_3000, instr=0x2008_0005, we=1, waddr=8, wdata=5) with out_ready=1:
  - frame 0x0000_3000, 0x2008_0005, 0x8008_0000, 0x0000_0005;
  - out_last on the 4th word only.
- Retire with we=0, waddr=9, wdata=0x1234 → w2 = 0x0009_0000 (plus seq), w3 = 0.
- out_ready=0 for 5 cycles during W1 → out_word holds the instr value and the state holds, then resumes in order.
- DEPTH=16, out_ready=0, 20 consecutive retires:
  - 16 stored, drop_cnt=4, overflow=1;
  - on drain, the seq values of the stored records are 0–15.
- FIFO full, a W3 handshake and in_valid in the same cycle → no drop; the count stays 16.
- Assert rst=0 mid-frame (in W2) → out_valid=0 and drop_cnt=0 immediately; after release, the FIFO is empty and the next retire carries seq=0.
